// File: rtl/clk_div_ctrl_pkg.sv
//------------------------------------------------------------------------------
// clk_div_ctrl_pkg : shared state encoding and default width for clk_div_ctrl
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_counter.sv
//------------------------------------------------------------------------------
// clk_div_counter : half-period counter, wraps to zero on reaching limit
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_counter
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == limit);

  // Wrapping on tc keeps count within limit, so limit = all-ones never overflows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//------------------------------------------------------------------------------
// clk_div_ctrl : run/idle clock divider with glitch-free ratio change handshake
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DEFAULT,
  parameter int unsigned RST_HALF = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_half
);

  state_t           state;
  logic             pend_v;
  logic [CNT_W-1:0] pend_half;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             cfg_fire;
  logic             boundary;

  assign cfg_ready = (state == IDLE) || !pend_v;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign busy      = (state == RUN);
  assign boundary  = (state == RUN) && tc && !clk_out;

  clk_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (state != RUN),
    .limit (active_half),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      clk_out     <= 1'b0;
      rise_tick   <= 1'b0;
      pend_v      <= 1'b0;
      pend_half   <= '0;
      active_half <= CNT_W'(RST_HALF);
    end else begin
      rise_tick <= 1'b0;
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          if (cfg_fire) begin
            active_half <= cfg_half;
          end
          if (en) begin
            state     <= RUN;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
          end
        end
        RUN: begin
          if (boundary) begin
            // A boundary-cycle transfer is only possible with nothing pending.
            if (cfg_fire) begin
              active_half <= cfg_half;
            end else if (pend_v) begin
              active_half <= pend_half;
            end
            pend_v <= 1'b0;
            if (en) begin
              clk_out   <= 1'b1;
              rise_tick <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (tc) begin
              clk_out <= 1'b0;
            end
            if (cfg_fire) begin
              pend_half <= cfg_half;
              pend_v    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//------------------------------------------------------------------------------
// tb_clk_div_ctrl : directed self-checking bench for clk_div_ctrl
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             clk_out;
  logic             rise_tick;
  logic             busy;
  logic [CNT_W-1:0] active_half;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_ctrl #(
    .CNT_W    (CNT_W),
    .RST_HALF (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .clk_out     (clk_out),
    .rise_tick   (rise_tick),
    .busy        (busy),
    .active_half (active_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks {clk_out, rise_tick} over whole periods starting at a high-phase first cycle.
  task automatic expect_wave(input string tag, input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < hi; i++) begin
        check(tag, {30'b0, clk_out, rise_tick}, {30'b0, 1'b1, (i == 0)});
        tick();
      end
      for (int i = 0; i < lo; i++) begin
        check(tag, {30'b0, clk_out, rise_tick}, 32'd0);
        tick();
      end
    end
  endtask

  initial begin
    int nh;
    int nr;
    int bad;
    int guard;

    reset     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;

    // Reset state
    #12;
    check("rst_clk_out", clk_out, 0);
    check("rst_rise", rise_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_half", active_half, 0);
    check("rst_ready", cfg_ready, 1);
    #2 reset = 1'b1;
    tick();
    check("idle_clk_out", clk_out, 0);

    // Default ratio: period 2
    en = 1'b1;
    tick();
    check("r0_busy", busy, 1);
    expect_wave("r0_wave", 1, 1, 3);
    en = 1'b0;
    expect_wave("r0_stop", 1, 1, 1);
    check("r0_idle_busy", busy, 0);
    check("r0_idle_clk", clk_out, 0);

    // Load half=2 in IDLE, then run 3/3
    cfg_valid = 1'b1;
    cfg_half  = 8'd2;
    check("h2_ready", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    check("h2_load", active_half, 2);
    check("h2_idle_busy", busy, 0);
    en = 1'b1;
    tick();
    check("h2_busy", busy, 1);
    expect_wave("h2_wave", 3, 3, 2);

    // Offer half=0 in the high phase: pending until boundary
    check("p0_h0_rise", rise_tick, 1);
    cfg_valid = 1'b1;
    cfg_half  = 8'd0;
    tick();
    cfg_valid = 1'b0;
    check("p0_ready_lo", cfg_ready, 0);
    check("p0_half_kept", active_half, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p0_ready_hold", cfg_ready, 0);
    end
    check("p0_low_last", clk_out, 0);
    tick();
    check("p0_applied", active_half, 0);
    check("p0_ready_back", cfg_ready, 1);
    expect_wave("p0_wave", 1, 1, 2);

    // Boundary-cycle transfer goes straight to active_half
    tick();
    check("bp_boundary_low", clk_out, 0);
    check("bp_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_half  = 8'd3;
    tick();
    cfg_valid = 1'b0;
    check("bp_applied", active_half, 3);
    check("bp_rise", rise_tick, 1);
    check("bp_ready_after", cfg_ready, 1);

    // Drop en one cycle into the high phase: full 4/4 then IDLE
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("st_high", {clk_out, rise_tick}, 2'b10);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("st_low", {clk_out, rise_tick}, 2'b00);
      check("st_busy_run", busy, 1);
      tick();
    end
    check("st_idle_busy", busy, 0);
    nr = 0;
    for (int i = 0; i < 8; i++) begin
      nr += int'(rise_tick) + int'(clk_out);
      tick();
    end
    check("st_no_rise", nr, 0);

    // Reset mid high phase at half=5
    cfg_valid = 1'b1;
    cfg_half  = 8'd5;
    tick();
    cfg_valid = 1'b0;
    check("rm_load", active_half, 5);
    en = 1'b1;
    tick();
    tick();
    tick();
    check("rm_high", clk_out, 1);
    reset = 1'b0;
    #1;
    check("rm_clk_out", clk_out, 0);
    check("rm_half", active_half, 0);
    check("rm_busy", busy, 0);
    #2 reset = 1'b1;
    tick();
    expect_wave("rm_wave", 1, 1, 2);
    en = 1'b0;
    expect_wave("rm_stop", 1, 1, 1);
    check("rm_idle", busy, 0);

    // Maximum ratio: half=255 gives a 512-cycle period
    cfg_valid = 1'b1;
    cfg_half  = 8'd255;
    tick();
    cfg_valid = 1'b0;
    check("mx_load", active_half, 255);
    en = 1'b1;
    tick();
    nh  = 0;
    nr  = 0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      nh += int'(clk_out);
      nr += int'(rise_tick);
      if (clk_out !== (i < 256)) bad++;
      tick();
    end
    check("mx_high_cnt", nh, 256);
    check("mx_rise_cnt", nr, 1);
    check("mx_shape", bad, 0);
    check("mx_next_rise", {clk_out, rise_tick}, 2'b11);
    en = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 600) begin
      tick();
      guard++;
    end
    check("mx_drain_busy", busy, 0);
    check("mx_drain_len", guard, 512);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the half-period count.
REQ-002 SHALL have parameter RST_HALF, default 0, active_half value after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  run request, level-sensitive.
REQ-006 SHALL have port cfg_valid  input  1  new ratio offered.
REQ-007 SHALL have port cfg_half  input  CNT_W  offered half-period minus one.
REQ-008 SHALL have port cfg_ready  output  1  ratio can be accepted; a transfer occurs when cfg_valid and cfg_ready are both high at a clk edge.
REQ-009 SHALL have port clk_out  output  1  divided clock, registered.
REQ-010 SHALL have port rise_tick  output  1  one-cycle pulse, high exactly in cycles where clk_out has just risen.
REQ-011 SHALL have port busy  output  1  high whenever the state is RUN.
REQ-012 SHALL have port active_half  output  CNT_W  ratio currently in use.

Function
REQ-013 SHALL implement states IDLE and RUN, plus a pending-config flag pend_v with a register pend_half.
REQ-014 In IDLE, clk_out, count and rise_tick SHALL be 0 and cfg_ready SHALL be 1; an accepted cfg_half SHALL load active_half on the same edge.
REQ-015 In IDLE with en=1 at an edge, the state SHALL become RUN, clk_out SHALL become 1, rise_tick SHALL pulse and count SHALL clear, all on that edge.
REQ-016 In RUN, count SHALL increment each cycle; when count==active_half, count SHALL clear and clk_out SHALL toggle, giving high and low phases of active_half+1 cycles each.
REQ-017 A period boundary SHALL be the cycle with count==active_half and clk_out==0.
REQ-018 At a boundary with en=0, the state SHALL return to IDLE, clk_out SHALL stay 0 and no rise SHALL occur.
REQ-019 At a boundary with en=1, clk_out SHALL rise, and if pend_v=1 active_half SHALL take pend_half and pend_v SHALL clear on that edge.
REQ-020 In RUN, cfg_ready SHALL equal !pend_v, and an accepted cfg_half SHALL be stored in pend_half with pend_v set.
REQ-021 A transfer in the boundary cycle SHALL apply cfg_half directly to active_half on that edge, bypassing pend_half.
REQ-022 A pending config SHALL still be applied when the boundary ends the run (en=0); the state SHALL enter IDLE with the new active_half.
REQ-023 en deasserted and reasserted before a boundary SHALL have no effect; clk_out SHALL never produce a truncated high or low phase.
REQ-024 count SHALL be CNT_W bits and never exceed active_half; cfg_half=2^CNT_W-1 SHALL yield a period of 2^(CNT_W+1) cycles with no overflow.

Reset
REQ-025 Reset low SHALL immediately force state IDLE, clk_out=0, rise_tick=0, count=0, pend_v=0, active_half=RST_HALF and busy=0, independent of clk.
REQ-026 Reset release SHALL take effect at the first clk edge with reset high; a truncated clk_out pulse caused by reset mid-run is permitted.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, RUN) and the default CNT_W constant.
REQ-028 The half-period counter with terminal-count detect SHALL be one sub-module, clk_div_counter; the FSM and config handshake SHALL stay in clk_div_ctrl.

Verification
REQ-029 Reset then en=1 with default ratio -> clk_out period 2 cycles (1 high/1 low), with rise_tick every 2 cycles.
REQ-030 In IDLE, load cfg_half=2, then en=1 -> clk_out high 3 cycles then low 3 cycles, busy=1, active_half=2.
REQ-031 Running at half=2, load cfg_half=0 during the high phase -> cfg_ready goes 0, the current period completes 3/3, then 1/1 follows, and cfg_ready returns to 1 at the boundary.
REQ-032 Running at half=3, drop en one cycle into the high phase -> full 4 high/4 low phases, then IDLE, busy=0 and no further rise_tick.
REQ-033 Reset pulled low mid high phase at half=5 -> clk_out=0 and active_half=RST_HALF immediately; after release and en=1, period 2.
REQ-034 CNT_W=8 with cfg_half=255 -> clk_out period 512 cycles, with exactly one rise_tick per period.
